// File: rtl/sleep_timer_bank.sv
// sleep_timer_bank
//   Bank of NUM_CH independent timeout timers plus a free-running divided clock.
//   Each channel is started with a timeout N and then runs in one-shot or
//   periodic mode. Expiry is reported by a one-cycle timeup pulse. In one-shot
//   mode a sticky expired flag is also set.
//
// Ports
//   inclok    in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   [NUM_CH]  start/restart request per channel (level)
//   cancel    in   [NUM_CH]  abort request per channel (wins over start)
//   periodic  in   [NUM_CH]  1 = periodic, 0 = one-shot; latched on start
//   load_val  in   [NUM_CH*CNT_W]  timeout per channel; latched on start
//   busy      out  [NUM_CH]  channel is counting
//   timeup    out  [NUM_CH]  one-cycle registered expiry pulse
//   expired   out  [NUM_CH]  sticky one-shot completion flag
//   outclok   out  divided clock, period CLK_DIV cycles
//
// Channel FSM
//   state  | meaning
//   IDLE   | not started, or cancelled
//   RUN    | counting toward the latched limit
//   DONE   | one-shot finished, expired held high
module sleep_timer_bank #(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 40,
  parameter logic [39:0] CLK_DIV = 40'd50000000
) (
  input  logic                      inclok,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*CNT_W-1:0]   load_val,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         timeup,
  output logic [NUM_CH-1:0]         expired,
  output logic                      outclok
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  // Holds N-1, so expiry is a direct compare and load_val=0 folds into N=1.
  logic [CNT_W-1:0] lim_q   [NUM_CH];
  logic [CNT_W-1:0] lim_d   [NUM_CH];
  logic [CNT_W-1:0] ld_w    [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] timeup_d, expired_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ld_w[g] = load_val[g*CNT_W +: CNT_W];
    assign busy[g] = (state_q[g] == S_RUN);
  end

  always_comb begin
    mode_d    = mode_q;
    timeup_d  = '0;
    expired_d = expired;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      lim_d[i]   = lim_q[i];
      if (cancel[i]) begin
        state_d[i]   = S_IDLE;
        cnt_d[i]     = '0;
        expired_d[i] = 1'b0;
      end else if (start[i]) begin
        // Start also covers restart from RUN and overrides a coincident expiry.
        state_d[i]   = S_RUN;
        cnt_d[i]     = '0;
        lim_d[i]     = (ld_w[i] == '0) ? '0 : ld_w[i] - CNT_W'(1);
        mode_d[i]    = periodic[i];
        expired_d[i] = 1'b0;
      end else if (state_q[i] == S_RUN) begin
        if (cnt_q[i] == lim_q[i]) begin
          timeup_d[i] = 1'b1;
          cnt_d[i]    = '0;
          if (!mode_q[i]) begin
            state_d[i]   = S_DONE;
            expired_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge inclok) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        lim_q[i]   <= '0;
      end
      mode_q  <= '0;
      timeup  <= '0;
      expired <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        lim_q[i]   <= lim_d[i];
      end
      mode_q  <= mode_d;
      timeup  <= timeup_d;
      expired <= expired_d;
    end
  end

  localparam int             DIV_W    = (CLK_DIV > 40'd2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 40'd1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 40'd2);

  logic [DIV_W-1:0] div_cnt, div_nxt;

  assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

  // outclok is derived from the next count so it lines up with div_cnt.
  always_ff @(posedge inclok) begin
    if (!rst_n) begin
      div_cnt <= '0;
      outclok <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      outclok <= (div_nxt >= DIV_HALF);
    end
  end

endmodule

// File: tb/tb_sleep_timer_bank.sv
module tb_sleep_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       start, cancel, periodic;
  logic [NUM_CH*CNT_W-1:0] load_val;
  logic [NUM_CH-1:0]       busy, timeup, expired;
  logic                    outclok;
  logic [NUM_CH-1:0]       busy5, timeup5, expired5;
  logic                    outclok5;

  always #5 clk = ~clk;

  sleep_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_DIV(40'd6)) dut (
    .inclok(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .periodic(periodic), .load_val(load_val), .busy(busy), .timeup(timeup),
    .expired(expired), .outclok(outclok));

  sleep_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_DIV(40'd5)) dut5 (
    .inclok(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .periodic(periodic), .load_val(load_val), .busy(busy5), .timeup(timeup5),
    .expired(expired5), .outclok(outclok5));

  typedef struct {
    logic       rst_n;
    logic [3:0] st, cn, pe;
    logic [7:0] ld0, ld1, ld2, ld3;
    logic [3:0] b, t, e;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] st, cn, pe,
                     input logic [7:0] l0, l1, l2, l3,
                     input logic [3:0] b, t, e);
    vec_t v;
    v.rst_n = r; v.st = st; v.cn = cn; v.pe = pe;
    v.ld0 = l0; v.ld1 = l1; v.ld2 = l2; v.ld3 = l3;
    v.b = b; v.t = t; v.e = e;
    vecs.push_back(v);
  endtask

  // Idle cycle with no requests, expecting the given outputs.
  task automatic idle(input int n, input logic [3:0] b, t, e);
    for (int i = 0; i < n; i++) add(1, 0, 0, 0, 0, 0, 0, 0, b, t, e);
  endtask

  initial begin
    // Reset held with start asserted on every channel.
    for (int i = 0; i < 3; i++) add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0);
    // One-shot ch0, N=5, start at edge k=4.
    add(1, 4'h1, 0, 0, 8'd5, 0, 0, 0, 4'h1, 0, 0);
    idle(4, 4'h1, 0, 0);
    idle(1, 4'h0, 4'h1, 4'h1);
    idle(1, 4'h0, 4'h0, 4'h1);
    // Periodic ch1, N=3, start at k=11; restart with N=4 at k+7.
    add(1, 4'h2, 0, 4'h2, 0, 8'd3, 0, 0, 4'h2, 0, 4'h1);
    idle(2, 4'h2, 0, 4'h1);
    idle(1, 4'h2, 4'h2, 4'h1);
    idle(2, 4'h2, 0, 4'h1);
    idle(1, 4'h2, 4'h2, 4'h1);
    add(1, 4'h2, 0, 4'h2, 0, 8'd4, 0, 0, 4'h2, 0, 4'h1);
    idle(3, 4'h2, 0, 4'h1);
    idle(1, 4'h2, 4'h2, 4'h1);
    add(1, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    // ch2 N=4, cancel+start on the expiry edge.
    add(1, 4'h4, 0, 0, 0, 0, 8'd4, 0, 4'h4, 0, 4'h1);
    idle(3, 4'h4, 0, 4'h1);
    add(1, 4'h4, 4'h4, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    idle(1, 0, 0, 4'h1);
    // ch3 start+cancel from IDLE.
    add(1, 4'h8, 4'h8, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    idle(1, 0, 0, 4'h1);
    // ch0 load 0 one-shot alongside ch1 N=2 periodic.
    add(1, 4'h3, 0, 4'h2, 8'd0, 8'd2, 0, 0, 4'h3, 0, 0);
    idle(1, 4'h2, 4'h1, 4'h1);
    idle(1, 4'h2, 4'h2, 4'h1);
    idle(1, 4'h2, 4'h0, 4'h1);
    idle(1, 4'h2, 4'h2, 4'h1);
    add(1, 0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    // ch3 N=1 periodic: timeup continuously high, cancel suppresses expiry.
    add(1, 4'h8, 0, 4'h8, 0, 0, 0, 8'd1, 4'h8, 0, 4'h1);
    idle(2, 4'h8, 4'h8, 4'h1);
    add(1, 0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 4'h1);
    // Reset mid-count, then a fresh N=3 one-shot counts from zero.
    add(1, 4'h1, 0, 0, 8'd6, 0, 0, 0, 4'h1, 0, 0);
    idle(2, 4'h1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4'h1, 0, 0, 8'd3, 0, 0, 0, 4'h1, 0, 0);
    idle(2, 4'h1, 0, 0);
    idle(1, 0, 4'h1, 4'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n    = vecs[i].rst_n;
      start    = vecs[i].st;
      cancel   = vecs[i].cn;
      periodic = vecs[i].pe;
      load_val = {vecs[i].ld3, vecs[i].ld2, vecs[i].ld1, vecs[i].ld0};
      @(negedge clk);
      chk($sformatf("v%0d busy", i),    32'(busy),    32'(vecs[i].b));
      chk($sformatf("v%0d timeup", i),  32'(timeup),  32'(vecs[i].t));
      chk($sformatf("v%0d expired", i), 32'(expired), 32'(vecs[i].e));
      if (!vecs[i].rst_n) begin
        chk($sformatf("v%0d outclok6 rst", i), 32'(outclok),  32'(0));
        chk($sformatf("v%0d outclok5 rst", i), 32'(outclok5), 32'(0));
      end
    end

    // Divider waveforms from a known reset point.
    rst_n = 1'b0; start = '0; cancel = '0; periodic = '0; load_val = '0;
    @(negedge clk);
    chk("div rst outclok6", 32'(outclok),  32'(0));
    chk("div rst outclok5", 32'(outclok5), 32'(0));
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk($sformatf("div6 j%0d", j), 32'(outclok),  32'((j % 6) >= 3));
      chk($sformatf("div5 j%0d", j), 32'(outclok5), 32'((j % 5) >= 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sleep_timer_bank.md
Name: sleep_timer_bank

Overview:
- Bank of NUM_CH independent programmable sleep/timeout timers, plus one free-running divided-clock output.
- Each channel loads its own timeout and runs in one-shot or periodic mode. It signals expiry with a one-cycle pulse and a sticky expired flag, and can be restarted or cancelled mid-count.
- Sits between the top-level state machine and its wait states; the FSM starts a channel and waits on its expiry.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CNT_W, 40, width of each channel counter and load value.
- CLK_DIV, 40'd50000000, period in inclok cycles of outclok (>=2).

Ports:
- inclok  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of inclok.
- start  in  NUM_CH  per-channel start/restart request, level-sampled each cycle.
- cancel  in  NUM_CH  per-channel abort request.
- periodic  in  NUM_CH  mode per channel: 1=periodic, 0=one-shot; sampled only when start is accepted.
- load_val  in  NUM_CH*CNT_W  timeout in cycles per channel; channel i uses bits [i*CNT_W +: CNT_W]; sampled only when start is accepted.
- busy  out  NUM_CH  channel counting (RUN state).
- timeup  out  NUM_CH  one-cycle expiry pulse, registered.
- expired  out  NUM_CH  sticky one-shot completion flag.
- outclok  out  1  divided clock.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All channels go to IDLE; counters and latched load/mode are cleared.
  - busy=0, timeup=0, expired=0.
  - Divider counter=0, outclok=0.
  - Reset overrides every other input; reset mid-count discards the count with no pulse.
- Per-channel FSM, with states IDLE, RUN, DONE:
  - IDLE / DONE + start=1, cancel=0:
    - Latch N = max(load_val_i, 1) and the periodic mode bit.
    - Counter=0, go to RUN, expired=0.
  - RUN, counter < N-1: counter increments by 1 each cycle.
  - RUN, counter == N-1 (the expiry edge):
    - timeup=1 for the following cycle.
    - Periodic: counter=0, stay in RUN.
    - One-shot: go to DONE, expired=1, busy=0.
  - RUN + start=1 (no cancel):
    - Restart: relatch N and mode, counter=0, no pulse this cycle.
    - Start wins over a coincident expiry, so the expiry is suppressed.
  - Any state + cancel=1:
    - Go to IDLE, counter=0, expired=0, no pulse.
    - Cancel wins over start and over a coincident expiry.
- Latency and counting:
  - Start accepted at edge k gives timeup high during the cycle after edge k+N; busy is high from edge k.
  - Periodic mode pulses every N cycles.
  - N=1 periodic gives timeup continuously high.
  - load_val=0 behaves exactly as load_val=1.
- Counter is CNT_W bits and never wraps, because it resets at N-1 <= 2^CNT_W-2.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Divider:
  - Free-running counter 0..CLK_DIV-1, wraps to 0.
  - outclok=0 while count < CLK_DIV/2 (integer division), else 1.
  - outclok is registered, glitch-free, and unaffected by the channels.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=all ones -> busy=timeup=expired=0 and outclok=0 throughout. After release, channels stay IDLE until start.
- One-shot: ch0 load_val=5, periodic=0, start pulsed at edge k -> busy=1 from k, timeup[0]=1 only in the cycle after k+5, expired[0]=1 from k+5 onward, busy=0.
- Periodic with restart:
  - ch1 load_val=3, periodic=1 -> timeup[1] pulses at k+3, k+6, k+9.
  - Restart with load_val=4 at k+7 -> next pulse at k+11, no pulse at k+9.
- Cancel collision:
  - ch2 load_val=4; assert cancel and start together at k+4, the expiry edge -> no pulse, ch2 IDLE, expired=0.
  - Separately, ch3 start+cancel in the same cycle from IDLE -> stays IDLE.
- Zero load and independence:
  - ch0 load_val=0 one-shot -> pulse one cycle after start.
  - Concurrently ch1 load_val=2 periodic -> pulses every 2 cycles, unaffected by ch0.
- Divider: CLK_DIV=6 -> outclok 0 for 3 cycles, 1 for 3, period 6. CLK_DIV=5 -> low 2, high 3.
- Reset mid-count: reset during RUN -> all outputs clear with no pulse, and the next start counts from zero.
